// File: rtl/cpu_pkg.sv
// Shared datapath constants and MEM/WB bundles for the pipelined MIPS core.
package cpu_pkg;

  localparam int          DATA_W  = 32;
  localparam int          REG_AW  = 5;
  localparam logic [4:0]  LINK_RG = 5'd31;
  localparam logic [31:0] PC_INC  = 32'd4;

  typedef struct packed {
    logic RegDst;
    logic RegWr;
    logic IsLink;
    logic IsByteW;
    logic ExtopM;
    logic MemtoReg;
  } wb_ctrl_t;

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] alu_res;
    logic [DATA_W-1:0] mem_rdata;
    logic [REG_AW-1:0] rt;
    logic [REG_AW-1:0] rd;
    wb_ctrl_t          ctrl;
  } mem_wb_t;

endpackage

// File: rtl/wb_byte_ext.sv
// Byte-to-word extender for byte loads: zero or sign extension.
module wb_byte_ext
  import cpu_pkg::*;
(
  input  logic [7:0]        byte_i,
  input  logic              sext_i,
  output logic [DATA_W-1:0] word_o
);

  always_comb begin
    word_o = {{(DATA_W-8){sext_i & byte_i[7]}}, byte_i};
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with write-back select and forwarding outputs.
// Optional WB_RETIRE_CNT_EN adds a retired-instruction counter port.
module mem_wb_stage
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              m_valid,
  input  logic [DATA_W-1:0] m_pc,
  input  logic [DATA_W-1:0] m_alu_res,
  input  logic [DATA_W-1:0] m_mem_rdata,
  input  logic [REG_AW-1:0] m_rt,
  input  logic [REG_AW-1:0] m_rd,
  input  logic              m_RegDst,
  input  logic              m_RegWr,
  input  logic              m_IsLink,
  input  logic              m_IsByteW,
  input  logic              m_ExtopM,
  input  logic              m_MemtoReg,
  input  logic              stall,
  input  logic              flush,
  output logic [REG_AW-1:0] w_rt,
  output logic [REG_AW-1:0] w_rd,
  output logic              RegDst,
  output logic              RegWr,
  output logic              IsLink,
  output logic              IsByteW,
  output logic              ExtopM,
  output logic [DATA_W-1:0] out_pc,
  output logic [DATA_W-1:0] busW,
  output logic              wb_fwd_en,
  output logic [REG_AW-1:0] wb_fwd_dst,
  output logic [DATA_W-1:0] wb_fwd_val
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [31:0]       retire_cnt
`endif
);

  mem_wb_t           st_q, st_d;
  logic [DATA_W-1:0] byte_word;

  // Flush clears the whole payload so every output reads as after reset.
  always_comb begin
    st_d = st_q;
    if (flush) begin
      st_d = '0;
    end else if (!stall) begin
      st_d.valid         = m_valid;
      st_d.pc            = m_pc;
      st_d.alu_res       = m_alu_res;
      st_d.mem_rdata     = m_mem_rdata;
      st_d.rt            = m_rt;
      st_d.rd            = m_rd;
      st_d.ctrl.RegDst   = m_RegDst;
      st_d.ctrl.RegWr    = m_RegWr;
      st_d.ctrl.IsLink   = m_IsLink;
      st_d.ctrl.IsByteW  = m_IsByteW;
      st_d.ctrl.ExtopM   = m_ExtopM;
      st_d.ctrl.MemtoReg = m_MemtoReg;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) st_q <= '0;
    else     st_q <= st_d;
  end

  wb_byte_ext u_ext (
    .byte_i (busW[7:0]),
    .sext_i (st_q.ctrl.ExtopM),
    .word_o (byte_word)
  );

  always_comb begin
    RegDst  = st_q.ctrl.RegDst;
    RegWr   = st_q.valid & st_q.ctrl.RegWr;
    IsLink  = st_q.ctrl.IsLink;
    IsByteW = st_q.ctrl.IsByteW;
    ExtopM  = st_q.ctrl.ExtopM;
    out_pc  = st_q.pc;
    if (st_q.ctrl.IsLink) begin
      busW       = st_q.pc + PC_INC;
      w_rt       = LINK_RG;
      w_rd       = LINK_RG;
      wb_fwd_dst = LINK_RG;
      wb_fwd_val = busW;
    end else begin
      busW       = st_q.ctrl.MemtoReg ? st_q.mem_rdata : st_q.alu_res;
      w_rt       = st_q.rt;
      w_rd       = st_q.rd;
      wb_fwd_dst = st_q.ctrl.RegDst ? st_q.rd : st_q.rt;
      wb_fwd_val = st_q.ctrl.IsByteW ? byte_word : busW;
    end
    wb_fwd_en = RegWr & (wb_fwd_dst != '0);
  end

`ifdef WB_RETIRE_CNT_EN
  logic [31:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + {31'd0, st_q.valid & (flush | ~stall)};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign retire_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: vector table, corner sequences,
// and randomized traffic against a behavioural model.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        m_valid;
  logic [31:0] m_pc, m_alu_res, m_mem_rdata;
  logic [4:0]  m_rt, m_rd;
  logic        m_RegDst, m_RegWr, m_IsLink, m_IsByteW, m_ExtopM, m_MemtoReg;
  logic        stall, flush;
  logic [4:0]  w_rt, w_rd, wb_fwd_dst;
  logic        RegDst, RegWr, IsLink, IsByteW, ExtopM, wb_fwd_en;
  logic [31:0] out_pc, busW, wb_fwd_val;
`ifdef WB_RETIRE_CNT_EN
  logic [31:0] retire_cnt;
`endif

  always #5 clk = ~clk;

  mem_wb_stage dut (
    .clk(clk), .rst(rst), .m_valid(m_valid), .m_pc(m_pc),
    .m_alu_res(m_alu_res), .m_mem_rdata(m_mem_rdata),
    .m_rt(m_rt), .m_rd(m_rd), .m_RegDst(m_RegDst), .m_RegWr(m_RegWr),
    .m_IsLink(m_IsLink), .m_IsByteW(m_IsByteW), .m_ExtopM(m_ExtopM),
    .m_MemtoReg(m_MemtoReg), .stall(stall), .flush(flush),
    .w_rt(w_rt), .w_rd(w_rd), .RegDst(RegDst), .RegWr(RegWr),
    .IsLink(IsLink), .IsByteW(IsByteW), .ExtopM(ExtopM),
    .out_pc(out_pc), .busW(busW), .wb_fwd_en(wb_fwd_en),
    .wb_fwd_dst(wb_fwd_dst), .wb_fwd_val(wb_fwd_val)
`ifdef WB_RETIRE_CNT_EN
    , .retire_cnt(retire_cnt)
`endif
  );

  typedef struct {
    logic        v;
    logic [31:0] pc, alu, rdata;
    logic [4:0]  rt, rd;
    logic        dst, wr, lnk, bw, ex, m2r;
    logic        e_wr, e_en;
    logic [31:0] e_bus, e_val;
    logic [4:0]  e_dst, e_wrt, e_wrd;
  } vec_t;

  typedef struct {
    logic        v;
    logic [31:0] pc, alu, rdata;
    logic [4:0]  rt, rd;
    logic        dst, wr, lnk, bw, ex, m2r;
  } mdl_t;

  int          checks = 0;
  int          failures = 0;
  mdl_t        m;
  logic [31:0] rc;
  vec_t        vt[7];

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", n, a, e);
    end
  endtask

  task automatic drive(input vec_t x);
    m_valid = x.v; m_pc = x.pc; m_alu_res = x.alu; m_mem_rdata = x.rdata;
    m_rt = x.rt; m_rd = x.rd; m_RegDst = x.dst; m_RegWr = x.wr;
    m_IsLink = x.lnk; m_IsByteW = x.bw; m_ExtopM = x.ex;
    m_MemtoReg = x.m2r;
  endtask

  task automatic step(input logic s, input logic f);
    stall = s; flush = f;
    @(posedge clk);
    if (m.v && (f || !s)) rc = rc + 1;
    if (f) m = '{default: '0};
    else if (!s)
      m = '{v: m_valid, pc: m_pc, alu: m_alu_res, rdata: m_mem_rdata,
            rt: m_rt, rd: m_rd, dst: m_RegDst, wr: m_RegWr,
            lnk: m_IsLink, bw: m_IsByteW, ex: m_ExtopM, m2r: m_MemtoReg};
    #1;
  endtask

  task automatic model_check(input string tag);
    logic [31:0] bus, val, b;
    logic [4:0]  dst;
    logic        wr;
    wr  = m.v && m.wr;
    bus = m.lnk ? m.pc + 32'd4 : (m.m2r ? m.rdata : m.alu);
    dst = m.lnk ? 5'd31 : (m.dst ? m.rd : m.rt);
    b   = bus % 256;
    if (m.lnk || !m.bw) val = bus;
    else if (m.ex && b >= 128) val = b - 32'd256;
    else val = b;
    chk({tag, ".RegWr"}, RegWr, wr);
    chk({tag, ".busW"}, busW, bus);
    chk({tag, ".dst"}, wb_fwd_dst, dst);
    chk({tag, ".val"}, wb_fwd_val, val);
    chk({tag, ".en"}, wb_fwd_en, wr && dst != 0);
    chk({tag, ".w_rt"}, w_rt, m.lnk ? 5'd31 : m.rt);
    chk({tag, ".w_rd"}, w_rd, m.lnk ? 5'd31 : m.rd);
    chk({tag, ".pc"}, out_pc, m.pc);
    chk({tag, ".ctl"}, {RegDst, IsLink, IsByteW, ExtopM},
        {m.dst, m.lnk, m.bw, m.ex});
  endtask

  initial begin
    vec_t  r;
    logic [31:0] hold;
    rc = '0;
    m = '{default: '0};
    vt[0] = '{1, 32'h100, 32'h1234, 32'hDEAD, 3, 5, 1, 1, 0, 0, 0, 0,
              1, 1, 32'h1234, 32'h1234, 5, 3, 5};
    vt[1] = '{1, 32'h104, 32'h40, 32'hF0, 7, 9, 0, 1, 0, 1, 1, 1,
              1, 1, 32'hF0, 32'hFFFFFFF0, 7, 7, 9};
    vt[2] = '{1, 32'h108, 32'h40, 32'hF0, 7, 9, 0, 1, 0, 1, 0, 1,
              1, 1, 32'hF0, 32'hF0, 7, 7, 9};
    vt[3] = '{1, 32'hFFFFFFFC, 32'h55, 32'h81, 2, 4, 0, 1, 1, 1, 1, 1,
              1, 1, 32'h0, 32'h0, 31, 31, 31};
    vt[4] = '{1, 32'h10C, 32'h77, 32'h0, 6, 0, 1, 1, 0, 0, 0, 0,
              1, 0, 32'h77, 32'h77, 0, 6, 0};
    vt[5] = '{1, 32'h110, 32'h99, 32'h0, 8, 1, 1, 0, 0, 0, 0, 0,
              0, 0, 32'h99, 32'h99, 1, 8, 1};
    vt[6] = '{0, 32'h114, 32'h3C, 32'h0, 8, 2, 1, 1, 0, 0, 0, 0,
              0, 0, 32'h3C, 32'h3C, 2, 8, 2};

    rst = 1'b1; stall = 0; flush = 0;
    drive(vt[0]);
    #12;
    chk("reset.RegWr", RegWr, 0);
    chk("reset.busW", busW, 0);
    chk("reset.en", wb_fwd_en, 0);
    chk("reset.pc", out_pc, 0);
    @(negedge clk); rst = 1'b0;

    foreach (vt[i]) begin
      drive(vt[i]);
      step(0, 0);
      chk($sformatf("vec%0d.RegWr", i), RegWr, vt[i].e_wr);
      chk($sformatf("vec%0d.busW", i), busW, vt[i].e_bus);
      chk($sformatf("vec%0d.dst", i), wb_fwd_dst, vt[i].e_dst);
      chk($sformatf("vec%0d.en", i), wb_fwd_en, vt[i].e_en);
      chk($sformatf("vec%0d.val", i), wb_fwd_val, vt[i].e_val);
      chk($sformatf("vec%0d.w_rt", i), w_rt, vt[i].e_wrt);
      chk($sformatf("vec%0d.w_rd", i), w_rd, vt[i].e_wrd);
    end

    // Stall freezes the ALU write while inputs keep changing.
    drive(vt[0]);
    step(0, 0);
    drive(vt[3]);
    for (int k = 0; k < 3; k++) begin
      step(1, 0);
      chk("stall.busW", busW, 32'h1234);
      chk("stall.RegWr", RegWr, 1);
      chk("stall.dst", wb_fwd_dst, 5);
    end
    step(1, 1);
    chk("stflush.RegWr", RegWr, 0);
    chk("stflush.en", wb_fwd_en, 0);
    chk("stflush.busW", busW, 0);

    // Async reset in the middle of a stalled valid write.
    drive(vt[0]);
    step(0, 0);
    stall = 1;
    #2 rst = 1'b1;
    #1;
    chk("midrst.RegWr", RegWr, 0);
    chk("midrst.busW", busW, 0);
    chk("midrst.en", wb_fwd_en, 0);
    m = '{default: '0};
    rc = '0;
    @(negedge clk); rst = 1'b0;
    step(1, 0);
    chk("postrst.RegWr", RegWr, 0);

`ifdef WB_RETIRE_CNT_EN
    for (int k = 0; k < 4; k++) begin
      drive(vt[k]);
      step(0, 0);
    end
    drive(vt[6]);
    step(0, 0);
    step(1, 0);
    chk("retire4", retire_cnt, 32'd4);
`endif

    for (int k = 0; k < 400; k++) begin
      r.v = $urandom_range(0, 3) != 0;
      r.pc = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFC : $urandom;
      r.alu = $urandom; r.rdata = $urandom;
      r.rt = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
      r.rd = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
      {r.dst, r.wr, r.lnk, r.bw, r.ex, r.m2r} = 6'($urandom);
      drive(r);
      step($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0);
      model_check($sformatf("rnd%0d", k));
`ifdef WB_RETIRE_CNT_EN
      chk("rnd.retire", retire_cnt, rc);
`endif
    end

    hold = rc;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
